// File: rtl/text_console_writer_if.sv
// Character-stream and text-VRAM bus bundle for text_console_writer.
// master: the console writer itself; slave: the character source / VRAM side.
interface text_console_writer_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  in_char_valid;
  logic                  out_char_ready;
  logic [7:0]            in_char;
  logic [7:0]            in_attr;
  logic                  out_vram_we;
  logic [ADDR_WIDTH-1:0] out_vram_waddr;
  logic [15:0]           out_vram_wdata;
  logic [ADDR_WIDTH-1:0] out_vram_raddr;
  logic [15:0]           in_vram_rdata;
  logic [6:0]            out_cursor_col;
  logic [4:0]            out_cursor_row;

  modport master (
    input  in_char_valid, in_char, in_attr, in_vram_rdata,
    output out_char_ready, out_vram_we, out_vram_waddr, out_vram_wdata,
           out_vram_raddr, out_cursor_col, out_cursor_row
  );

  modport slave (
    output in_char_valid, in_char, in_attr, in_vram_rdata,
    input  out_char_ready, out_vram_we, out_vram_waddr, out_vram_wdata,
           out_vram_raddr, out_cursor_col, out_cursor_row
  );
endinterface

// File: rtl/text_console_writer.sv
// Text console writer: accepts characters, maintains a cursor, handles
// CR/LF/BS/FF, scrolls by copying rows through the VRAM read port and
// clears the screen after reset or form feed.
module text_console_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter int         ADDR_WIDTH = 13,
  parameter logic [7:0] RESET_ATTR = 8'h07
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  text_console_writer_if.master bus
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]      CELLS_LAST    = CNT_W'(COLS * ROWS - 1);
  localparam logic [CNT_W-1:0]      COPY_N        = CNT_W'((ROWS - 1) * COLS);
  localparam logic [CNT_W-1:0]      FILL_LAST     = CNT_W'(COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] COLS_A        = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW_BASE = ADDR_WIDTH'((ROWS - 1) * COLS);
  localparam logic [6:0]            COL_LAST      = 7'(COLS - 1);
  localparam logic [4:0]            ROW_LAST      = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_EXEC,
    S_SCROLL_COPY,
    S_SCROLL_FILL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       col_q, col_d;
  logic [4:0]       row_q, row_d;
  logic [7:0]       char_q, char_d;
  logic [7:0]       attr_q, attr_d;

  logic [ADDR_WIDTH-1:0] cnt_a;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  printable;

  assign cnt_a     = cnt_q[ADDR_WIDTH-1:0];
  assign cur_addr  = ADDR_WIDTH'(row_q) * COLS_A + ADDR_WIDTH'(col_q);
  assign printable = (char_q >= 8'h20) && (char_q <= 8'h7E);

  // State, counter, cursor and latched character registers
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      char_q  <= '0;
      attr_q  <= RESET_ATTR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      char_q  <= char_d;
      attr_q  <= attr_d;
    end
  end

  // Next-state, counter and cursor update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    char_d  = char_q;
    attr_d  = attr_q;
    unique case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CELLS_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.in_char_valid) begin
          char_d  = bus.in_char;
          attr_d  = bus.in_attr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (printable) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) state_d = S_SCROLL_COPY;
            else                   row_d   = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          case (char_q)
            8'h0D: col_d = '0;
            8'h0A: begin
              col_d = '0;
              if (row_q == ROW_LAST) state_d = S_SCROLL_COPY;
              else                   row_d   = row_q + 1'b1;
            end
            8'h08: if (col_q != '0) col_d = col_q - 1'b1;
            8'h0C: begin
              col_d   = '0;
              row_d   = '0;
              state_d = S_CLEAR;
            end
            default: ;
          endcase
        end
      end
      S_SCROLL_COPY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == COPY_N) begin
          cnt_d   = '0;
          state_d = S_SCROLL_FILL;
        end
      end
      S_SCROLL_FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FILL_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // VRAM strobes and handshake, forced low while reset is asserted
  always_comb begin
    bus.out_char_ready = 1'b0;
    bus.out_vram_we    = 1'b0;
    bus.out_vram_waddr = '0;
    bus.out_vram_wdata = '0;
    bus.out_vram_raddr = '0;
    unique case (state_q)
      S_CLEAR: begin
        bus.out_vram_we    = 1'b1;
        bus.out_vram_waddr = cnt_a;
        bus.out_vram_wdata = {attr_q, 8'h20};
      end
      S_IDLE: bus.out_char_ready = 1'b1;
      S_EXEC: begin
        if (printable) begin
          bus.out_vram_we    = 1'b1;
          bus.out_vram_waddr = cur_addr;
          bus.out_vram_wdata = {attr_q, char_q};
        end else if (char_q == 8'h08 && col_q != '0) begin
          bus.out_vram_we    = 1'b1;
          bus.out_vram_waddr = cur_addr - 1'b1;
          bus.out_vram_wdata = {attr_q, 8'h20};
        end
      end
      S_SCROLL_COPY: begin
        // Read runs one cycle ahead of the write; the last cycle only writes
        if (cnt_q < COPY_N) bus.out_vram_raddr = COLS_A + cnt_a;
        if (cnt_q != '0) begin
          bus.out_vram_we    = 1'b1;
          bus.out_vram_waddr = cnt_a - 1'b1;
          bus.out_vram_wdata = bus.in_vram_rdata;
        end
      end
      S_SCROLL_FILL: begin
        bus.out_vram_we    = 1'b1;
        bus.out_vram_waddr = LAST_ROW_BASE + cnt_a;
        bus.out_vram_wdata = {attr_q, 8'h20};
      end
      default: ;
    endcase
    if (in_reset) begin
      bus.out_char_ready = 1'b0;
      bus.out_vram_we    = 1'b0;
      bus.out_vram_waddr = '0;
      bus.out_vram_wdata = '0;
      bus.out_vram_raddr = '0;
    end
  end

  assign bus.out_cursor_col = col_q;
  assign bus.out_cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a synchronous VRAM model.
module tb_text_console_writer;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int AW    = 13;
  localparam int CELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  text_console_writer_if #(.ADDR_WIDTH(AW)) bus ();

  text_console_writer #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .ADDR_WIDTH (AW),
    .RESET_ATTR (8'h07)
  ) dut (
    .in_clock (clk),
    .in_reset (rst),
    .bus      (bus)
  );

  logic [15:0] mem [0:(1<<AW)-1];
  logic        preload = 1'b0;
  int unsigned wr_cnt  = 0;

  // VRAM model: synchronous read, write port, one-shot row-index preload
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < CELLS; a++) mem[a] <= {8'h07, 8'(a / COLS)};
    end else if (bus.out_vram_we) begin
      mem[bus.out_vram_waddr] <= bus.out_vram_wdata;
    end
    bus.in_vram_rdata <= mem[bus.out_vram_raddr];
    if (bus.out_vram_we) wr_cnt <= wr_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present a character at a negedge; returns at the negedge of the EXEC cycle
  task automatic send(input logic [7:0] ch, input logic [7:0] at);
    bus.in_char       = ch;
    bus.in_attr       = at;
    bus.in_char_valid = 1'b1;
    @(negedge clk);
    bus.in_char_valid = 1'b0;
  endtask

  task automatic put(input logic [7:0] ch, input logic [7:0] at);
    send(ch, at);
    @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.out_char_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Follow a full-screen clear from its first cycle until ready returns
  task automatic clear_check(input logic [15:0] data, output int n, output int bad);
    n   = 0;
    bad = 0;
    while (!bus.out_char_ready && n < 10000) begin
      if (!bus.out_vram_we || int'(bus.out_vram_waddr) != n || bus.out_vram_wdata != data) bad++;
      @(negedge clk);
      n++;
    end
  endtask

  int n, bad;
  int unsigned w0;

  initial begin
    bus.in_char_valid = 1'b0;
    bus.in_char       = '0;
    bus.in_attr       = '0;

    // Reset and post-reset clear
    repeat (3) @(negedge clk);
    check("rst_we",    32'(bus.out_vram_we), 0);
    check("rst_ready", 32'(bus.out_char_ready), 0);
    check("rst_waddr", 32'(bus.out_vram_waddr), 0);
    check("rst_col",   32'(bus.out_cursor_col), 0);
    check("rst_row",   32'(bus.out_cursor_row), 0);
    w0 = wr_cnt;
    rst = 1'b0;
    #1;
    clear_check(16'h0720, n, bad);
    check("clr_ready_cycle", n, 2400);
    check("clr_seq_bad", bad, 0);
    check("clr_wr_count", wr_cnt - w0, 2400);
    bad = 0;
    for (int a = 0; a < CELLS; a++) if (mem[a] != 16'h0720) bad++;
    check("clr_mem_bad", bad, 0);

    // 'A' at (0,0)
    send(8'h41, 8'h1F);
    check("A_we",    32'(bus.out_vram_we), 1);
    check("A_waddr", 32'(bus.out_vram_waddr), 0);
    check("A_wdata", 32'(bus.out_vram_wdata), 'h1F41);
    check("A_ready_exec", 32'(bus.out_char_ready), 0);
    @(negedge clk);
    check("A_col",   32'(bus.out_cursor_col), 1);
    check("A_row",   32'(bus.out_cursor_row), 0);
    check("A_ready", 32'(bus.out_char_ready), 1);
    check("A_we_idle", 32'(bus.out_vram_we), 0);

    // Line wrap at (5,79)
    repeat (5) put(8'h0A, 8'h07);
    repeat (79) put(8'h2E, 8'h07);
    check("pre_Z_col", 32'(bus.out_cursor_col), 79);
    check("pre_Z_row", 32'(bus.out_cursor_row), 5);
    send(8'h5A, 8'h07);
    check("Z_waddr", 32'(bus.out_vram_waddr), 479);
    check("Z_wdata", 32'(bus.out_vram_wdata), 'h075A);
    @(negedge clk);
    check("Z_col", 32'(bus.out_cursor_col), 0);
    check("Z_row", 32'(bus.out_cursor_row), 6);

    // Form feed with attr 0x02
    w0 = wr_cnt;
    send(8'h0C, 8'h02);
    check("FF_we_exec", 32'(bus.out_vram_we), 0);
    @(negedge clk);
    check("FF_col", 32'(bus.out_cursor_col), 0);
    check("FF_row", 32'(bus.out_cursor_row), 0);
    clear_check(16'h0220, n, bad);
    check("FF_ready_cycle", n, 2400);
    check("FF_seq_bad", bad, 0);
    check("FF_wr_count", wr_cnt - w0, 2400);
    check("FF_mem_first", 32'(mem[0]), 'h0220);
    check("FF_mem_last",  32'(mem[CELLS-1]), 'h0220);

    // Backspace at column 0 and column 4
    repeat (3) put(8'h0A, 8'h07);
    send(8'h08, 8'h07);
    check("BS0_we", 32'(bus.out_vram_we), 0);
    @(negedge clk);
    check("BS0_col", 32'(bus.out_cursor_col), 0);
    check("BS0_row", 32'(bus.out_cursor_row), 3);
    repeat (4) put(8'h61, 8'h07);
    send(8'h08, 8'h07);
    check("BS4_we",    32'(bus.out_vram_we), 1);
    check("BS4_waddr", 32'(bus.out_vram_waddr), 243);
    check("BS4_wdata", 32'(bus.out_vram_wdata), 'h0720);
    @(negedge clk);
    check("BS4_col", 32'(bus.out_cursor_col), 3);
    check("BS4_row", 32'(bus.out_cursor_row), 3);

    // Scroll from LF at (29,10)
    repeat (26) put(8'h0A, 8'h07);
    repeat (10) put(8'h62, 8'h07);
    check("pre_scr_col", 32'(bus.out_cursor_col), 10);
    check("pre_scr_row", 32'(bus.out_cursor_row), 29);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    w0 = wr_cnt;
    send(8'h0A, 8'h07);
    check("scr_we_exec", 32'(bus.out_vram_we), 0);
    @(negedge clk);
    check("scr_k0_we",    32'(bus.out_vram_we), 0);
    check("scr_k0_raddr", 32'(bus.out_vram_raddr), 80);
    @(negedge clk);
    check("scr_k1_we",    32'(bus.out_vram_we), 1);
    check("scr_k1_waddr", 32'(bus.out_vram_waddr), 0);
    check("scr_k1_wdata", 32'(bus.out_vram_wdata), 'h0701);
    wait_ready(n);
    check("scr_ready_cycle", n, 2400);
    check("scr_wr_count", wr_cnt - w0, 2400);
    bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mem[r*COLS + c] != ((r < ROWS-1) ? {8'h07, 8'(r + 1)} : 16'h0720)) bad++;
    check("scr_mem_bad", bad, 0);
    check("scr_col", 32'(bus.out_cursor_col), 0);
    check("scr_row", 32'(bus.out_cursor_row), 29);

    // Reset in the middle of a scroll copy
    send(8'h0A, 8'h07);
    repeat (100) @(negedge clk);
    check("mid_copy_we", 32'(bus.out_vram_we), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_we",    32'(bus.out_vram_we), 0);
    check("abort_ready", 32'(bus.out_char_ready), 0);
    check("abort_raddr", 32'(bus.out_vram_raddr), 0);
    check("abort_waddr", 32'(bus.out_vram_waddr), 0);
    check("abort_wdata", 32'(bus.out_vram_wdata), 0);
    check("abort_col",   32'(bus.out_cursor_col), 0);
    check("abort_row",   32'(bus.out_cursor_row), 0);
    @(negedge clk);
    w0 = wr_cnt;
    rst = 1'b0;
    #1;
    clear_check(16'h0720, n, bad);
    check("reclr_ready_cycle", n, 2400);
    check("reclr_seq_bad", bad, 0);
    check("reclr_wr_count", wr_cnt - w0, 2400);
    check("reclr_col", 32'(bus.out_cursor_col), 0);
    check("reclr_row", 32'(bus.out_cursor_row), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
